// File: rtl/ev_counter_ctrl_if.sv
// ev_counter_ctrl_if: valid/ready command port of the event counter sequencer
interface ev_counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ev_counter_ctrl.sv
// ev_counter_ctrl: command-driven sequencer for the event counter's clear/increment strobes
module ev_counter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    ev_counter_ctrl_if.slave bus,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_SET_LIMIT, OP_SET_PRESCALE, OP_START, OP_STOP} op_t;
    state_t                st, st_nx;
    logic [WIDTH-1:0]      limit, limit_nx;
    logic [PRESCALE_W-1:0] prescale, prescale_nx, pcnt, pcnt_nx;
    logic                  auto_reload, auto_reload_nx;
    logic                  at_limit, accept;
    assign at_limit      = cnt_q == limit;
    assign bus.cmd_ready = ena && (st == IDLE || (st == RUN && !at_limit));
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign busy          = st != IDLE;
    assign state         = st;
    // state and configuration registers; ena=0 holds them via the next-state defaults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            limit       <= '1;
            prescale    <= '0;
            pcnt        <= '0;
            auto_reload <= 1'b0;
        end else begin
            st          <= st_nx;
            limit       <= limit_nx;
            prescale    <= prescale_nx;
            pcnt        <= pcnt_nx;
            auto_reload <= auto_reload_nx;
        end
    end
    // sequencing: strobes from the current state, then an accepted command overrides the next state
    always_comb begin
        st_nx          = st;
        limit_nx       = limit;
        prescale_nx    = prescale;
        pcnt_nx        = pcnt;
        auto_reload_nx = auto_reload;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        done           = 1'b0;
        if (ena) begin
            case (st)
                IDLE: ;
                LOAD: begin
                    cnt_clr = 1'b1;
                    pcnt_nx = '0;
                    st_nx   = RUN;
                end
                RUN: begin
                    if (at_limit) begin
                        st_nx = DONE;
                    end else if (pcnt == prescale) begin
                        cnt_en  = 1'b1;
                        pcnt_nx = '0;
                    end else begin
                        pcnt_nx = pcnt + 1'b1;
                    end
                end
                DONE: begin
                    done  = 1'b1;
                    st_nx = auto_reload ? LOAD : IDLE;
                end
            endcase
            if (accept) begin
                case (op_t'(bus.cmd_op))
                    OP_SET_LIMIT:    limit_nx = bus.cmd_data;
                    OP_SET_PRESCALE: prescale_nx = bus.cmd_data[PRESCALE_W-1:0];
                    OP_START: begin
                        auto_reload_nx = bus.cmd_data[0];
                        st_nx          = LOAD;
                    end
                    OP_STOP: begin
                        auto_reload_nx = 1'b0;
                        st_nx          = IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ev_counter_ctrl.sv
// tb_ev_counter_ctrl: scoreboard bench for ev_counter_ctrl with a behavioural counter datapath
module tb_ev_counter_ctrl;
    localparam int W = 8;
    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [W-1:0] cnt;
    logic         cnt_clr, cnt_en, busy, done;
    logic [1:0]   state;
    int           cyc = 0;
    int           en_count = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         exp_q[$];
    exp_t         m_e;
    ev_counter_ctrl_if #(.WIDTH(W)) bus ();
    ev_counter_ctrl #(.WIDTH(W), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus), .cnt_q(cnt),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .done(done), .state(state)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // behavioural counter datapath reacting to the strobes on the same edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // monitor: every done pulse must match the oldest expected terminal event
    always @(negedge clk) begin
        if (cnt_en) en_count++;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                m_e = exp_q.pop_front();
                check("done_cycle", cyc, m_e.cyc);
                check("done_cnt", int'(cnt), m_e.cnt);
            end
        end
    end
    task automatic send(input logic [1:0] op, input logic [W-1:0] data, output int e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        e = -1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                e = cyc;
                bus.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("send_timeout", int'(bus.cmd_ready), 1);
    endtask
    task automatic config_lp(input int l, input int p);
        int e;
        send(2'b00, W'(l), e);
        send(2'b01, W'(p), e);
    endtask
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("done_wait", exp_q.size(), 0);
    endtask
    task automatic expect_done(input int c, input int v);
        exp_t x;
        x.cyc = c;
        x.cnt = v;
        exp_q.push_back(x);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int e, e0, base, l, p;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr", cnt_clr, 0);
        check("rst_en", cnt_en, 0);
        check("rst_ready", bus.cmd_ready, 1);
        // limit 3, prescale 0, single shot
        config_lp(3, 0);
        base = en_count;
        send(2'b10, 8'd0, e0);
        check("clr_at_start", cnt_clr, 1);
        check("load_not_ready", bus.cmd_ready, 0);
        expect_done(e0 + 5, 3);
        wait_done(100);
        @(posedge clk);
        #1;
        check("idle_after_done", state, 0);
        check("cnt_final", cnt, 3);
        check("en_count_l3", en_count - base, 3);
        // limit 2, prescale 2
        config_lp(2, 2);
        base = en_count;
        send(2'b10, 8'd0, e0);
        expect_done(e0 + 8, 2);
        wait_done(100);
        check("en_count_l2p2", en_count - base, 2);
        // randomized single-shot runs
        for (int k = 0; k < 6; k++) begin
            l = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 3));
            config_lp(l, p);
            base = en_count;
            send(2'b10, 8'd0, e0);
            expect_done(e0 + l * (p + 1) + 2, l);
            wait_done(200);
            check("en_count_rand", en_count - base, l);
        end
        // auto-reload, three periods, then STOP
        config_lp(1, 0);
        send(2'b10, 8'd1, e0);
        expect_done(e0 + 3, 1);
        expect_done(e0 + 7, 1);
        expect_done(e0 + 11, 1);
        wait_done(100);
        send(2'b11, 8'd0, e);
        check("stop_state", state, 0);
        check("stop_busy", busy, 0);
        base = en_count;
        repeat (20) @(negedge clk);
        #1;
        check("stop_no_en", en_count - base, 0);
        // limit 0
        config_lp(0, 0);
        base = en_count;
        send(2'b10, 8'd0, e0);
        expect_done(e0 + 2, 0);
        wait_done(50);
        check("en_count_l0", en_count - base, 0);
        // raise limit to 255 while running at cnt_q=5
        config_lp(10, 0);
        send(2'b10, 8'd0, e0);
        for (int i = 0; i < 50 && !(cnt == 5 && state == 2'b10); i++) @(negedge clk);
        check("reach_cnt5", cnt, 5);
        send(2'b00, 8'hFF, e);
        expect_done(e0 + 257, 255);
        wait_done(400);
        // ena gap of 5 cycles mid-run
        config_lp(4, 0);
        send(2'b10, 8'd0, e0);
        expect_done(e0 + 11, 4);
        repeat (2) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("gap_en", cnt_en, 0);
            check("gap_state", state, 2);
            check("gap_ready", bus.cmd_ready, 0);
            @(negedge clk);
        end
        ena = 1'b1;
        wait_done(100);
        // asynchronous reset mid-run, then limit/prescale back at reset values
        config_lp(4, 0);
        send(2'b10, 8'd0, e0);
        repeat (2) @(negedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_busy", busy, 0);
        check("arst_en", cnt_en, 0);
        check("arst_clr", cnt_clr, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", bus.cmd_ready, 1);
        send(2'b10, 8'd0, e0);
        expect_done(e0 + 257, 255);
        wait_done(400);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
